// File: rtl/seq_shift_add_mult.sv
// -----------------------------------------------------------------------------
// seq_shift_add_mult
//
// Handshaked sequential shift-add multiplier. It consumes one multiplier bit per
// clock, supports unsigned and two's-complement operands, and holds its product
// until the next accepted start.
//
// Ports:
//   clk    in   1          system clock, rising edge
//   rst    in   1          asynchronous, active-low reset
//   start  in   1          request a multiply (ignored while busy)
//   sgn    in   1          1 = two's-complement operands, 0 = unsigned
//   A      in   WIDTH      multiplicand, captured with start
//   B      in   WIDTH      multiplier, captured with start
//   busy   out  1          multiply in progress
//   done   out  1          one-cycle pulse, P valid
//   P      out  2*WIDTH    product, held until the next accepted start
//
// Optional feature (compile-time macro SEQ_MULT_EARLY_TERM_EN):
//   When defined, the operation finishes as soon as every unprocessed bit of B
//   is zero; the pending right shifts are applied in one step. When undefined,
//   latency is always WIDTH cycles and no early-termination logic exists.
//
// Datapath: r_pp is a (2*WIDTH+1)-bit partial product. Its upper WIDTH+1 bits
// (one guard bit) are the accumulator. The adder's second operand comes from
// r_add_op, which is loaded one step ahead and only when the next bit of B is 1,
// so runs of zero bits leave it untouched.
// -----------------------------------------------------------------------------
module seq_shift_add_mult #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic                 r_sgn;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH:0]     r_pp;
  logic [WIDTH:0]       r_add_op;
  logic [2*WIDTH-1:0]   r_p;

  logic [CNT_W-1:0]     w_cnt_inc;
  logic                 w_bit;
  logic                 w_last;
  logic                 w_next_last;
  logic                 w_finish;
  logic [WIDTH:0]       w_hi;
  logic [WIDTH+1:0]     w_hi_x;
  logic [WIDTH+1:0]     w_op_x;
  logic [WIDTH+1:0]     w_sum;
  logic [2*WIDTH+1:0]   w_cat;
  logic [2*WIDTH:0]     w_pp_shift;
  logic [WIDTH:0]       w_a_ext;
  logic [WIDTH:0]       w_op_nxt;
  logic [WIDTH:0]       w_start_op;
  logic [2*WIDTH-1:0]   w_p_final;

  // ---------------------------------------------------------------------------
  // Step datapath
  // ---------------------------------------------------------------------------
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_bit       = r_b[r_cnt];
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_next_last = (w_cnt_inc == CNT_W'(WIDTH - 1));

  // The accumulator is extended to WIDTH+2 bits so the top bit of the sum is
  // both the sign (signed mode) and the carry (unsigned mode, always 0 here
  // because the guard bit is clear); it becomes the shifted-in MSB.
  assign w_hi   = r_pp[2*WIDTH:WIDTH];
  assign w_hi_x = {r_sgn & w_hi[WIDTH], w_hi};
  assign w_op_x = {r_sgn & r_add_op[WIDTH], r_add_op};
  assign w_sum  = w_bit ? (w_hi_x + w_op_x) : w_hi_x;

  assign w_cat      = {w_sum, r_pp[WIDTH-1:0]};
  assign w_pp_shift = (2*WIDTH+1)'(w_cat >> 1);

  // Look-ahead operand for the next step: the last bit of a signed multiplier
  // carries negative weight, so its operand is stored already negated.
  assign w_a_ext    = {r_sgn & r_a[WIDTH-1], r_a};
  assign w_op_nxt   = (w_next_last && r_sgn) ? (-w_a_ext) : w_a_ext;
  // Step 0 is never the last step (WIDTH >= 2), so no negation at start.
  assign w_start_op = {sgn & A[WIDTH-1], A};

`ifdef SEQ_MULT_EARLY_TERM_EN
  logic                 w_rem_zero;
  logic [CNT_W-1:0]     w_shamt;
  logic [2*WIDTH:0]     w_aligned;

  // Two-stage shift avoids the counter wrap at the last step.
  assign w_rem_zero = (((r_b >> r_cnt) >> 1) == '0);
  assign w_shamt    = CNT_W'(WIDTH - 1) - r_cnt;
  // Remaining steps would be shift-only, so an arithmetic shift finishes them.
  assign w_aligned  = $signed(w_pp_shift) >>> w_shamt;
  assign w_finish   = w_last || w_rem_zero;
  assign w_p_final  = (2*WIDTH)'(w_aligned);
`else
  assign w_finish   = w_last;
  assign w_p_final  = (2*WIDTH)'(w_pp_shift);
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the default assignment first keeps this block free of latches on
  // paths that do not change state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_finish) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand, counter and product registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sgn    <= 1'b0;
      r_cnt    <= '0;
      r_pp     <= '0;
      r_add_op <= '0;
      r_p      <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a   <= A;
            r_b   <= B;
            r_sgn <= sgn;
            r_cnt <= '0;
            r_pp  <= '0;
            if (B[0]) r_add_op <= w_start_op;
          end
        end
        S_RUN: begin
          r_pp  <= w_pp_shift;
          r_cnt <= w_cnt_inc;
          if (!w_finish && r_b[w_cnt_inc]) r_add_op <= w_op_nxt;
          if (w_finish) r_p <= w_p_final;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign P    = r_p;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// -----------------------------------------------------------------------------
// tb_seq_shift_add_mult
//
// Directed bench for seq_shift_add_mult at WIDTH=16. Each launch pushes the
// expected product and latency onto a scoreboard; the collector pops and
// compares when done rises. Latency expectations follow the
// SEQ_MULT_EARLY_TERM_EN macro when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_seq_shift_add_mult;

  localparam int W       = 16;
  localparam int MAX_CYC = 40;

  typedef struct {
    logic [2*W-1:0] p;
    int             lat;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic             sgn;
  logic [W-1:0]     A;
  logic [W-1:0]     B;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   P;

  exp_t             sb[$];
  logic [2*W-1:0]   last_p;
  int               n_cmp;
  int               n_fail;

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sgn   (sgn),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] model_p(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb_v;
    logic [2*W-1:0]        ua;
    logic [2*W-1:0]        ub;
    sa   = {{W{a[W-1]}}, a};
    sb_v = {{W{b[W-1]}}, b};
    ua   = {{W{1'b0}}, a};
    ub   = {{W{1'b0}}, b};
    return s ? (2*W)'(sa * sb_v) : (2*W)'(ua * ub);
  endfunction

  function automatic int model_lat(input logic [W-1:0] b);
    int lat;
    lat = W;
`ifdef SEQ_MULT_EARLY_TERM_EN
    lat = 1;
    for (int i = 0; i < W; i++) begin
      if (b[i]) lat = i + 1;
    end
`endif
    return lat;
  endfunction

  // Drive one start cycle; leaves the bench just after the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    e.p   = model_p(a, b, s);
    e.lat = model_lat(b);
    sb.push_back(e);
    A     = a;
    B     = b;
    sgn   = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait for done, checking P stability while busy. inj >= 0 pulses a stray
  // start (A=2, B=2) sampled at RUN step inj. chk_op checks the adder operand
  // register stays at op_exp throughout the run.
  task automatic collect(input string tag, input int inj, input bit chk_op,
                         input logic [W:0] op_exp);
    exp_t e;
    int   n;
    int   busy_cnt;
    bit   seen;
    e        = sb.pop_front();
    n        = 0;
    busy_cnt = busy ? 1 : 0;
    seen     = 1'b0;
    while (!seen && n < MAX_CYC) begin
      if (n == inj) begin
        start = 1'b1;
        A     = W'(2);
        B     = W'(2);
      end
      tick();
      n++;
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        check({tag, "_p_hold"}, 64'(P), 64'(last_p));
        if (chk_op) check({tag, "_addop"}, 64'(dut.r_add_op), 64'(op_exp));
      end
    end
    check({tag, "_latency"}, 64'(n), 64'(e.lat));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(e.lat));
    check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    check({tag, "_p"}, 64'(P), 64'(e.p));
    last_p = e.p;
  endtask

  task automatic check_idle(input string tag);
    tick();
    check({tag, "_done_fell"}, 64'(done), 64'(0));
    check({tag, "_busy_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int pulse_step;
    n_cmp  = 0;
    n_fail = 0;
    last_p = '0;
    rst    = 1'b0;
    start  = 1'b0;
    sgn    = 1'b0;
    A      = '0;
    B      = '0;

    // Reset state
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_p", 64'(P), 64'(0));
    rst = 1'b1;
    tick();

    // Unsigned maximum
    launch(16'hFFFF, 16'hFFFF, 1'b0);
    collect("umax", -1, 1'b0, '0);
    check_idle("umax");

    // Signed extremes, back-to-back
    launch(16'hFFFF, 16'hFFFF, 1'b1);
    collect("s_m1m1", -1, 1'b0, '0);
    launch(16'h8000, 16'h8000, 1'b1);
    collect("s_minmin", -1, 1'b0, '0);
    launch(16'h0003, 16'hFFFE, 1'b1);
    collect("s_3xm2", -1, 1'b0, '0);
    check_idle("signed");

    // Zero multiplier: the operand register keeps the last value loaded by
    // the previous run, the negated multiplicand -3 (17 bits).
    launch(16'h1234, 16'h0000, 1'b0);
    collect("bzero", -1, 1'b1, 17'h1FFFD);
    check_idle("bzero");

    // Stray start during RUN is ignored; start in DONE cycle is accepted
    pulse_step = (model_lat(16'd9) > 6) ? 5 : 1;
    launch(16'd7, 16'd9, 1'b0);
    collect("ignore", pulse_step, 1'b0, '0);
    launch(16'd5, 16'd6, 1'b0);
    collect("b2b", -1, 1'b0, '0);
    check_idle("b2b");

    // Small multiplier (early-termination candidate)
    launch(16'h00FF, 16'h0003, 1'b0);
    collect("early", -1, 1'b0, '0);
    check_idle("early");

    // Asynchronous reset mid-run
    launch(16'h1234, 16'h8001, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    check("mid_busy_before", 64'(busy), 64'(1));
    #2;
    rst = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_p", 64'(P), 64'(0));
    sb.delete();
    last_p = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_done", 64'(done), 64'(0));
    end
    rst = 1'b1;
    tick();
    check("post_rst_idle", 64'(busy), 64'(0));
    launch(16'd3, 16'd4, 1'b0);
    collect("after_rst", -1, 1'b0, '0);
    check_idle("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
- Parametrised, handshaked, low-power sequential shift-add multiplier.
- Successor to the fixed 16-bit ring-counter multiplier in the arithmetic datapath. Adds start/busy/done control, operand capture, signed/unsigned mode and a WIDTH parameter.
- Processes one multiplier bit per cycle. The adder operand register is updated only on 1-bits, so zero bits cost no adder toggling.

Parameters:
- WIDTH, 16, operand width in bits (>=2). Product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH), width of the internal step counter.

Ports:
- clk    in   1        system clock, rising edge
- rst    in   1        asynchronous, active-low reset
- start  in   1        request a multiply; sampled on rising clk
- sgn    in   1        1 = two's-complement operands, 0 = unsigned; captured with start
- A      in   WIDTH    multiplicand; captured with start
- B      in   WIDTH    multiplier; captured with start
- busy   out  1        high while a multiply is in progress
- done   out  1        one-cycle pulse: P is valid
- P      out  2*WIDTH  product; held until the next accepted start

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, P=0; counter, operand and partial-product registers all 0. Reset asserted mid-operation aborts the operation, with no done pulse.
- States: IDLE, RUN, DONE.
  - IDLE/DONE with start=1 at an edge: capture A, B, sgn; clear the partial product; counter=0; go to RUN; busy=1.
  - DONE with start=0: go to IDLE.
  - start while in RUN: ignored. Captured operands are unaffected.
- RUN edge k (k = 0..WIDTH-1) processes bit b_k of captured B:
  - hi = upper WIDTH+1 bits of the partial-product register (one guard bit).
  - If b_k=1 and k<WIDTH-1: hi = hi + ext(A).
  - If b_k=1 and k=WIDTH-1: hi = hi - ext(A) when sgn=1, hi + ext(A) when sgn=0.
  - If b_k=0: no add. The adder input register holds its previous value (low-power requirement; the bench checks it does not toggle).
  - ext(A) is sign-extended when sgn=1, zero-extended otherwise.
  - After the add, the whole register shifts right by 1. The shifted-in MSB is the guard bit's sign (sgn=1) or the carry (sgn=0).
  - Counter increments.
- At the edge processing k=WIDTH-1: P <= final product; state=DONE; done=1 and busy=0 for exactly one cycle.
- Latency: start sampled at edge t0 gives done high in the cycle following edge t0+WIDTH.
- Back-to-back: start=1 in the DONE cycle is accepted. The next done comes WIDTH cycles later.
- P changes only at the final RUN edge or on reset. It is stable while busy.
- Widths: no overflow is possible; the product is exact modulo 2^(2*WIDTH).
  - Unsigned max: (2^W-1)^2.
  - Signed extremes: (-2^(W-1))^2 = 2^(2W-2).

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined: at each RUN edge, after processing b_k, if all unprocessed higher bits of B are 0:
  - P <= the fully aligned product in that same edge (remaining shifts done in one step);
  - go to DONE.
  - Latency = max(index of highest 1 in B, 0) + 1 cycles.
  - A negative signed B never terminates early, because its MSB is 1.
- Undefined: fixed latency of WIDTH cycles, and no early-termination logic is synthesised.

Test Plan:
- WIDTH=16, sgn=0, A=0xFFFF, B=0xFFFF, start 1 cycle -> done in the 16th cycle after start, P=0xFFFE0001, busy high for 16 cycles.
- sgn=1: A=0xFFFF, B=0xFFFF -> P=0x00000001. A=0x8000, B=0x8000 -> P=0x40000000. A=0x0003, B=0xFFFE -> P=0xFFFFFFFA.
- sgn=0, A=0x1234, B=0x0000 -> P=0. The adder input register never changes during RUN. With SEQ_MULT_EARLY_TERM_EN, done arrives 1 cycle after start.
- Start A=7, B=9. Pulse start with A=2, B=2 at RUN step 5 -> ignored, P=63 at the normal time. Then start in the DONE cycle with A=5, B=6 -> P=30 exactly 16 cycles later.
- Drop rst to 0 at RUN step 8, between edges -> busy, done and P go to 0 immediately, with no done pulse. After release, a fresh start with A=3, B=4 -> P=12.
- SEQ_MULT_EARLY_TERM_EN, sgn=0, A=0x00FF, B=0x0003 -> done after 2 cycles, P=0x000002FD. Same operands without the macro -> done after 16 cycles, same P.
